// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared core types: datapath width and memory access sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int REGISTER_WIDTH = 32;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } mem_size_e;

  // An access faults when its size is illegal or the address is not
  // naturally aligned to that size.
  function automatic logic access_error(input mem_size_e size, input logic [1:0] addr_lo);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return addr_lo[0];
      WORD:    return (addr_lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational byte-lane handling for the load/store unit:
//               read-word reordering, load extraction/extension and
//               sub-word store merging.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align #(
  parameter int W  = 32,
  parameter int OW = 2
) (
  input  logic                  [1:0] size,
  input  logic                        is_unsigned,
  input  logic               [OW-1:0] offset,
  input  logic                [W-1:0] mem_rdata,
  input  logic                [W-1:0] old_word,
  input  logic                [W-1:0] wdata,
  output logic                [W-1:0] rdata_lanes,
  output logic                [W-1:0] load_data,
  output logic                [W-1:0] merge_data
);
  import riscv_pkg::*;

  localparam int NB = W / 8;

  logic [OW-1:0] off_hi;
  logic    [7:0] b_lo;
  logic    [7:0] b_hi;

  // Upper byte of a half access; wraps only for misaligned offsets, which
  // never reach this logic as a real access.
  assign off_hi = offset + OW'(1);

  // Memory returns the lowest-addressed byte in the top lane; flip it so
  // lane k of rdata_lanes holds byte aligned+k (write-lane order).
  always_comb begin
    rdata_lanes = '0;
    for (int k = 0; k < NB; k++) begin
      rdata_lanes[8*k +: 8] = mem_rdata[W-1-8*k -: 8];
    end
  end

  // Pick the addressed byte(s) little-endian and extend to full width.
  always_comb begin
    b_lo = rdata_lanes[8*int'(offset) +: 8];
    b_hi = rdata_lanes[8*int'(off_hi) +: 8];
    case (mem_size_e'(size))
      BYTE:    load_data = is_unsigned ? {{(W-8){1'b0}}, b_lo}
                                       : {{(W-8){b_lo[7]}}, b_lo};
      HALF:    load_data = is_unsigned ? {{(W-16){1'b0}}, b_hi, b_lo}
                                       : {{(W-16){b_hi[7]}}, b_hi, b_lo};
      default: load_data = rdata_lanes;
    endcase
  end

  // Overlay the store data onto the previously read word.
  always_comb begin
    merge_data = old_word;
    case (mem_size_e'(size))
      BYTE: merge_data[8*int'(offset) +: 8] = wdata[7:0];
      HALF: begin
        merge_data[8*int'(offset) +: 8] = wdata[7:0];
        merge_data[8*int'(off_hi) +: 8] = wdata[15:8];
      end
      WORD:    merge_data = wdata;
      default: merge_data = old_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit. Loads take one memory
//               cycle; sub-word stores do read-modify-write on a port that
//               only writes whole words. One-cycle response pulse, no
//               response backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int REGISTER_WIDTH = riscv_pkg::REGISTER_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic                [1:0] req_size,
  input  logic                      req_unsigned,
  input  logic [REGISTER_WIDTH-1:0] req_addr,
  input  logic [REGISTER_WIDTH-1:0] req_wdata,
  output logic                      rsp_valid,
  output logic [REGISTER_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_error,
  output logic                      mem_write_en,
  output logic [REGISTER_WIDTH-1:0] mem_write_data,
  output logic [REGISTER_WIDTH-1:0] mem_address,
  input  logic [REGISTER_WIDTH-1:0] mem_read_data
);
  import riscv_pkg::*;

  localparam int OFF_W = $clog2(REGISTER_WIDTH / 8);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOAD        = 3'd1,
    STORE_READ  = 3'd2,
    STORE_WRITE = 3'd3,
    RESP        = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic                      write_q, write_d;
  mem_size_e                 size_q,  size_d;
  logic                      uns_q,   uns_d;
  logic                      err_q,   err_d;
  logic [REGISTER_WIDTH-1:0] addr_q,  addr_d;
  logic [REGISTER_WIDTH-1:0] wdata_q, wdata_d;
  logic [REGISTER_WIDTH-1:0] rdata_q, rdata_d;
  logic [REGISTER_WIDTH-1:0] old_q,   old_d;

  logic [REGISTER_WIDTH-1:0] lane_rdata;
  logic [REGISTER_WIDTH-1:0] lane_load;
  logic [REGISTER_WIDTH-1:0] lane_merge;
  logic                      mem_active;

  lsu_lane_align #(
    .W  (REGISTER_WIDTH),
    .OW (OFF_W)
  ) u_lane_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .offset      (addr_q[OFF_W-1:0]),
    .mem_rdata   (mem_read_data),
    .old_word    (old_q),
    .wdata       (wdata_q),
    .rdata_lanes (lane_rdata),
    .load_data   (lane_load),
    .merge_data  (lane_merge)
  );

  // Outputs decode the registered state; reset overrides them immediately so
  // an aborted STORE_WRITE can never reach memory.
  assign req_ready      = (state_q == IDLE) && !rst;
  assign mem_active     = ((state_q == LOAD) || (state_q == STORE_READ) ||
                           (state_q == STORE_WRITE)) && !rst;
  assign mem_address    = mem_active ? {addr_q[REGISTER_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_write_en   = (state_q == STORE_WRITE) && !rst;
  assign mem_write_data = mem_write_en ? lane_merge : '0;
  assign rsp_valid      = (state_q == RESP) && !rst;
  assign rsp_error      = rsp_valid && err_q;
  assign rsp_rdata      = rsp_valid ? rdata_q : '0;

  // Next-state and datapath capture for the access sequencer.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    old_d   = old_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          write_d = req_write;
          size_d  = mem_size_e'(req_size);
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = access_error(mem_size_e'(req_size), req_addr[1:0]);
          rdata_d = '0;
          if (err_d) begin
            state_d = RESP;
          end else if (!req_write) begin
            state_d = LOAD;
          end else if (mem_size_e'(req_size) == WORD) begin
            state_d = STORE_WRITE;
          end else begin
            state_d = STORE_READ;
          end
        end
      end
      LOAD: begin
        rdata_d = lane_load;
        state_d = RESP;
      end
      STORE_READ: begin
        old_d   = lane_rdata;
        state_d = STORE_WRITE;
      end
      STORE_WRITE: state_d = RESP;
      RESP:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      size_q  <= BYTE;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      old_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      old_q   <= old_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit with a byte-array
//               reference memory and latency/response expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic  [1:0] req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_address;
  logic [31:0] mem_read_data;

  logic  [7:0] mem       [256];
  logic  [7:0] model_mem [256];
  logic        mem_init;
  logic  [7:0] ma;

  int          total = 0;
  int          bad   = 0;
  int          wr_count  = 0;
  int          rsp_count = 0;
  int          act_count = 0;
  logic [31:0] last_wd = '0;

  always #5 clk = ~clk;

  load_store_unit #(.REGISTER_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_error      (rsp_error),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_address    (mem_address),
    .mem_read_data  (mem_read_data)
  );

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      16:      return 8'h11;
      17:      return 8'h22;
      18:      return 8'h33;
      19:      return 8'h84;
      default: return 8'(i * 37 + 5);
    endcase
  endfunction

  // Data memory: combinational read (lowest address in the top byte),
  // little-endian lane write on the clock edge.
  assign ma = mem_address[7:0];
  assign mem_read_data = {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]};

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
    end else if (mem_write_en) begin
      for (int k = 0; k < 4; k++) mem[ma + 8'(k)] <= mem_write_data[8*k +: 8];
    end
    if (mem_write_en) begin
      wr_count <= wr_count + 1;
      last_wd  <= mem_write_data;
    end
    if (rsp_valid) rsp_count <= rsp_count + 1;
    if ((mem_address != 32'd0) || mem_write_en) act_count <= act_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input int a, input int sz, input logic uns);
    logic [31:0] v;
    case (sz)
      0: begin
        v = 32'(model_mem[a]);
        if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end
      1: begin
        v = 32'(model_mem[a]) + (32'(model_mem[a+1]) << 8);
        if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = 32'(model_mem[a]) + (32'(model_mem[a+1]) << 8) +
                   (32'(model_mem[a+2]) << 16) + (32'(model_mem[a+3]) << 24);
    endcase
    return v;
  endfunction

  // One complete request: predict, drive, wait for the response, compare.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input string tag, output logic [31:0] rd_obs);
    int          ai;
    int          b;
    int          exp_lat;
    int          wr0;
    int          act0;
    int          n;
    logic        seen;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] exp_wd;
    ai      = int'(a[7:0]);
    b       = ai - (ai % 4);
    exp_err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    exp_rd  = '0;
    exp_wd  = '0;
    if (exp_err) begin
      exp_lat = 1;
    end else if (!w) begin
      exp_lat = 2;
      exp_rd  = model_load(ai, int'(sz), uns);
    end else begin
      exp_lat = (sz == 2'd2) ? 2 : 3;
      model_mem[ai] = wd[7:0];
      if (sz != 2'd0) model_mem[ai+1] = wd[15:8];
      if (sz == 2'd2) begin
        model_mem[ai+2] = wd[23:16];
        model_mem[ai+3] = wd[31:24];
      end
      exp_wd = {model_mem[b+3], model_mem[b+2], model_mem[b+1], model_mem[b]};
    end

    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    wr0  = wr_count;
    act0 = act_count;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 8) begin
      @(negedge clk);
      n++;
      seen = rsp_valid;
    end
    rd_obs = rsp_rdata;
    check({tag, "_lat"},   32'(n), 32'(exp_lat));
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_err"},   32'(rsp_error), 32'(exp_err));
    check({tag, "_wrcnt"}, 32'(wr_count - wr0), (w && !exp_err) ? 32'd1 : 32'd0);
    if (w && !exp_err) check({tag, "_wdata"}, last_wd, exp_wd);
    if (exp_err) check({tag, "_noacc"}, 32'(act_count - act0), 32'd0);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          wr0;
    int          rsp0;
    int          r_ai;
    logic [1:0]  r_sz;
    for (int i = 0; i < 256; i++) model_mem[i] = init_byte(i);
    rst          = 1'b1;
    mem_init     = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready),    32'd0);
    check("rst_rsp_valid", 32'(rsp_valid),    32'd0);
    check("rst_rsp_error", 32'(rsp_error),    32'd0);
    check("rst_rsp_rdata", rsp_rdata,         32'd0);
    check("rst_mem_we",    32'(mem_write_en), 32'd0);
    check("rst_mem_wd",    mem_write_data,    32'd0);
    check("rst_mem_addr",  mem_address,       32'd0);
    rst      = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(req_ready), 32'd1);

    // Directed loads on 0x10..0x13 = 11 22 33 84
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, "lb_13", rd);
    check("lb_13_const", rd, 32'hFFFF_FF84);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, "lhu_12", rd);
    check("lhu_12_const", rd, 32'h0000_8433);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw_10", rd);
    check("lw_10_const", rd, 32'h8433_2211);

    // Byte store then read back
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hAB, "sb_11", rd);
    check("sb_11_wd_const", last_wd, 32'h8433_AB11);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw_10b", rd);
    check("lw_10b_const", rd, 32'h8433_AB11);

    // Misaligned half
    do_req(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, "lh_13_err", rd);

    // Reset during STORE_READ aborts the store
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = 1'b1;
    req_size     = 2'd1;
    req_unsigned = 1'b0;
    req_addr     = 32'h20;
    req_wdata    = 32'h0000_BEEF;
    check("abort_ready", 32'(req_ready), 32'd1);
    wr0  = wr_count;
    rsp0 = rsp_count;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_rd_addr", mem_address, 32'h20);
    rst = 1'b1;
    #1;
    check("abort_addr_forced", mem_address,     32'd0);
    check("abort_ready_forced", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after", 32'(req_ready),          32'd1);
    check("abort_no_write",    32'(wr_count - wr0),     32'd0);
    check("abort_no_rsp",      32'(rsp_count - rsp0),   32'd0);

    // Back-to-back requests held on req_valid
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = 1'b0;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_addr     = 32'h10;
    check("b2b_ready0", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_size     = 2'd0;
    req_unsigned = 1'b1;
    req_addr     = 32'h12;
    @(negedge clk);
    check("b2b_c1_ready", 32'(req_ready), 32'd0);
    check("b2b_c1_rsp",   32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("b2b_c2_rsp",   32'(rsp_valid), 32'd1);
    check("b2b_c2_ready", 32'(req_ready), 32'd0);
    check("b2b_c2_rdata", rsp_rdata, model_load(16, 2, 1'b0));
    @(negedge clk);
    check("b2b_c3_rsp",   32'(rsp_valid), 32'd0);
    check("b2b_c3_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("b2b_c4_rsp",   32'(rsp_valid), 32'd0);
    check("b2b_c4_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("b2b_c5_rsp",   32'(rsp_valid), 32'd1);
    check("b2b_c5_rdata", rsp_rdata, model_load(18, 0, 1'b1));

    // Randomized mix against the reference memory
    for (int t = 0; t < 60; t++) begin
      r_ai = 16 + int'($urandom_range(0, 31));
      r_sz = 2'($urandom_range(0, 3));
      do_req(1'($urandom_range(0, 1)), r_sz, 1'($urandom_range(0, 1)),
             32'(r_ai), $urandom, $sformatf("rnd%0d", t), rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
